c7bifu_redir_ctl: RTL and testbench

- Fetch-redirect scheduler in the IFU: one pending-redirect register shared by three requesters.
  - Backend exception/ertn.
  - EXU branch resolution.
  - Decode-stage direct branches.
- Decode target is dec_pc plus the branch offset produced by the IFU immediate decoder.
- Arbitrates by priority and holds the winning redirect until fetch accepts it (valid/ready).
- Issues the boot redirect after reset.

---
 rtl/c7bifu_redir_ctl_pkg.sv | 26 ++
 rtl/c7bifu_redir_ctl_prio.sv | 37 +++
 rtl/c7bifu_redir_ctl.sv | 111 +++++++++++
 tb/tb_c7bifu_redir_ctl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c7bifu_redir_ctl_pkg.sv
// IFU redirect defines: source and FSM encodings
// shared by the redirect scheduler and its priority mux.
package c7bifu_redir_ctl_pkg;

  localparam logic [1:0] C7_REDIR_BOOT = 2'd0;
  localparam logic [1:0] C7_REDIR_EXC  = 2'd1;
  localparam logic [1:0] C7_REDIR_EXU  = 2'd2;
  localparam logic [1:0] C7_REDIR_DEC  = 2'd3;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Lower source code means higher priority.
  // exc/exu replace an equal-priority held entry;
  // a held decode redirect is never replaced by dec.
  function automatic logic redir_wins(
    input logic [1:0] req_src,
    input logic [1:0] held_src
  );
    return (req_src < held_src) ||
           ((req_src == held_src) &&
            (req_src != C7_REDIR_DEC));
  endfunction

endpackage

// File: rtl/c7bifu_redir_ctl_prio.sv
// Redirect priority select: exc > exu > dec.
// Purely combinational.
module c7bifu_redir_prio
  import c7bifu_redir_ctl_pkg::*;
(
  input  logic        i_exc_vld,
  input  logic [31:0] i_exc_pc,
  input  logic        i_exu_vld,
  input  logic [31:0] i_exu_pc,
  input  logic        i_dec_req,
  input  logic [31:0] i_dec_tgt,
  output logic        o_req_vld,
  output logic [31:0] o_req_pc,
  output logic [1:0]  o_req_src
);

  // Pick the oldest requester; decode is youngest.
  always_comb begin
    o_req_vld = 1'b0;
    o_req_pc  = 32'd0;
    o_req_src = C7_REDIR_BOOT;
    if (i_exc_vld) begin
      o_req_vld = 1'b1;
      o_req_pc  = i_exc_pc;
      o_req_src = C7_REDIR_EXC;
    end else if (i_exu_vld) begin
      o_req_vld = 1'b1;
      o_req_pc  = i_exu_pc;
      o_req_src = C7_REDIR_EXU;
    end else if (i_dec_req) begin
      o_req_vld = 1'b1;
      o_req_pc  = i_dec_tgt;
      o_req_src = C7_REDIR_DEC;
    end
  end

endmodule

// File: rtl/c7bifu_redir_ctl.sv
// Fetch-redirect scheduler: one pending redirect
// shared by exc, exu and decode, plus boot redirect.
module c7bifu_redir_ctl
  import c7bifu_redir_ctl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_dec_valid,
  input  logic [31:0] i_dec_pc,
  input  logic [31:0] i_dec_br_offs,
  input  logic        i_dec_is_jump,
  input  logic        i_dec_is_bcond,
  input  logic        i_exu_redir_vld,
  input  logic [31:0] i_exu_redir_pc,
  input  logic        i_exc_vld,
  input  logic [31:0] i_exc_pc,
  output logic        o_redir_vld,
  output logic [31:0] o_redir_pc,
  output logic [1:0]  o_redir_src,
  input  logic        i_redir_rdy,
  output logic        o_fetch_kill,
  output logic        o_dec_stall
);

  logic [1:0]  r_state;
  logic        r_vld;
  logic [31:0] r_pc;
  logic [1:0]  r_src;
  logic        r_kill;

  logic        w_dec_req;
  logic [31:0] w_dec_tgt;
  logic        w_req_vld;
  logic [31:0] w_req_pc;
  logic [1:0]  w_req_src;
  logic        w_acc;

  // Backward conditional branches predicted taken.
  assign w_dec_req = i_dec_valid &
                     (i_dec_is_jump |
                      (i_dec_is_bcond & i_dec_br_offs[31]));
  assign w_dec_tgt = i_dec_pc + i_dec_br_offs;
  assign w_acc     = r_vld & i_redir_rdy;

  c7bifu_redir_prio u_prio (
    .i_exc_vld (i_exc_vld),
    .i_exc_pc  (i_exc_pc),
    .i_exu_vld (i_exu_redir_vld),
    .i_exu_pc  (i_exu_redir_pc),
    .i_dec_req (w_dec_req),
    .i_dec_tgt (w_dec_tgt),
    .o_req_vld (w_req_vld),
    .o_req_pc  (w_req_pc),
    .o_req_src (w_req_src)
  );

  // Redirect FSM and holding register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_BOOT;
      r_vld   <= 1'b1;
      r_pc    <= RESET_PC;
      r_src   <= C7_REDIR_BOOT;
      r_kill  <= 1'b0;
    end else begin
      r_kill <= w_acc;
      case (r_state)
        ST_BOOT: begin
          if (w_acc) begin
            r_state <= ST_IDLE;
            r_vld   <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (w_req_vld) begin
            r_state <= ST_HOLD;
            r_vld   <= 1'b1;
            r_pc    <= w_req_pc;
            r_src   <= w_req_src;
          end
        end
        ST_HOLD: begin
          if (w_acc && !w_req_vld) begin
            r_state <= ST_IDLE;
            r_vld   <= 1'b0;
          end else if (w_req_vld &&
                       (w_acc ||
                        redir_wins(w_req_src, r_src))) begin
            r_pc  <= w_req_pc;
            r_src <= w_req_src;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_vld   <= 1'b0;
        end
      endcase
    end
  end

  assign o_redir_vld  = r_vld;
  assign o_redir_pc   = r_pc;
  assign o_redir_src  = r_src;
  assign o_fetch_kill = r_kill;
  assign o_dec_stall  = (r_state == ST_HOLD) &
                        (r_src == C7_REDIR_DEC) &
                        ~i_redir_rdy;

endmodule

// File: tb/tb_c7bifu_redir_ctl.sv
// Self-checking bench for c7bifu_redir_ctl:
// directed plan scenarios plus randomized model compare.
module tb_c7bifu_redir_ctl;

  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_offs;
  logic        dec_jump;
  logic        dec_bcond;
  logic        exu_vld;
  logic [31:0] exu_pc;
  logic        exc_vld;
  logic [31:0] exc_pc;
  logic        redir_vld;
  logic [31:0] redir_pc;
  logic [1:0]  redir_src;
  logic        redir_rdy;
  logic        fetch_kill;
  logic        dec_stall;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  c7bifu_redir_ctl #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .i_dec_valid     (dec_valid),
    .i_dec_pc        (dec_pc),
    .i_dec_br_offs   (dec_offs),
    .i_dec_is_jump   (dec_jump),
    .i_dec_is_bcond  (dec_bcond),
    .i_exu_redir_vld (exu_vld),
    .i_exu_redir_pc  (exu_pc),
    .i_exc_vld       (exc_vld),
    .i_exc_pc        (exc_pc),
    .o_redir_vld     (redir_vld),
    .o_redir_pc      (redir_pc),
    .o_redir_src     (redir_src),
    .i_redir_rdy     (redir_rdy),
    .o_fetch_kill    (fetch_kill),
    .o_dec_stall     (dec_stall)
  );

  // Reference model: a pending slot with a boot flag.
  bit        m_boot;
  bit        m_pend;
  bit [31:0] m_pc;
  bit [1:0]  m_src;
  bit        m_kill;

  always @(posedge clk) begin
    bit        acc;
    bit        has;
    bit [1:0]  s;
    bit [31:0] p;
    bit        dreq;
    acc  = m_pend && redir_rdy;
    dreq = dec_valid &&
           (dec_jump || (dec_bcond && dec_offs[31]));
    has = 1'b1;
    if (exc_vld) begin
      s = 2'd1; p = exc_pc;
    end else if (exu_vld) begin
      s = 2'd2; p = exu_pc;
    end else if (dreq) begin
      s = 2'd3; p = dec_pc + dec_offs;
    end else begin
      has = 1'b0; s = 2'd0; p = 32'd0;
    end
    if (!resetn) begin
      m_boot = 1; m_pend = 1; m_pc = RST_PC;
      m_src = 0; m_kill = 0;
    end else begin
      m_kill = acc;
      if (m_boot) begin
        if (acc) begin
          m_boot = 0; m_pend = 0;
        end
      end else if (!m_pend || acc) begin
        m_pend = has;
        if (has) begin
          m_pc = p; m_src = s;
        end
      end else if (has &&
                   (s < m_src ||
                    (s == m_src && s != 2'd3))) begin
        m_pc = p; m_src = s;
      end
    end
  end

  function automatic bit m_stall();
    return m_pend && !m_boot && m_src == 2'd3 &&
           !redir_rdy;
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr_req();
    dec_valid = 0; dec_jump = 0; dec_bcond = 0;
    exu_vld = 0; exc_vld = 0;
    dec_pc = 0; dec_offs = 0;
    exu_pc = 0; exc_pc = 0;
  endtask

  task automatic test_reset();
    clr_req();
    redir_rdy = 0;
    resetn = 0;
    adv(); adv();
    resetn = 1;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) redir_rdy = 1;
      smp();
      ntot++;
      if ({redir_vld, redir_pc, redir_src,
           fetch_kill, dec_stall} !==
          {1'b1, RST_PC, 2'd0, 1'b0, 1'b0})
        $display("FAIL reset_c%0d: got v=%b pc=%h s=%0d k=%b st=%b want v=1 pc=%h s=0 k=0 st=0",
                 c, redir_vld, redir_pc, redir_src,
                 fetch_kill, dec_stall, RST_PC);
      else npass++;
      adv();
    end
    redir_rdy = 0;
    smp();
    ntot++;
    if ({redir_vld, fetch_kill} !== 2'b01)
      $display("FAIL reset_acc: got v=%b k=%b want v=0 k=1",
               redir_vld, fetch_kill);
    else npass++;
    adv();
    smp();
    ntot++;
    if ({redir_vld, fetch_kill} !== 2'b00)
      $display("FAIL reset_idle: got v=%b k=%b want v=0 k=0",
               redir_vld, fetch_kill);
    else npass++;
  endtask

  task automatic test_dec_jump();
    adv();
    dec_valid = 1; dec_jump = 1;
    dec_pc = 32'h1c000100; dec_offs = 32'hFFFFFFF0;
    redir_rdy = 1;
    adv();
    clr_req();
    smp();
    ntot++;
    if ({redir_vld, redir_pc, redir_src, dec_stall} !==
        {1'b1, 32'h1c0000F0, 2'd3, 1'b0})
      $display("FAIL dec_jump: got v=%b pc=%h s=%0d st=%b want v=1 pc=1c0000f0 s=3 st=0",
               redir_vld, redir_pc, redir_src, dec_stall);
    else npass++;
    adv();
    smp();
    ntot++;
    if ({redir_vld, fetch_kill} !== 2'b01)
      $display("FAIL dec_jump_acc: got v=%b k=%b want v=0 k=1",
               redir_vld, fetch_kill);
    else npass++;
  endtask

  task automatic test_bcond();
    adv();
    dec_valid = 1; dec_bcond = 1;
    dec_pc = 32'h1c000200; dec_offs = 32'h00000040;
    adv();
    clr_req();
    smp();
    ntot++;
    if (redir_vld !== 1'b0)
      $display("FAIL bcond_fwd: got v=%b want v=0", redir_vld);
    else npass++;
    adv();
    dec_valid = 1; dec_bcond = 1;
    dec_pc = 32'h1c000200; dec_offs = 32'hFFFFFFC0;
    adv();
    clr_req();
    smp();
    ntot++;
    if ({redir_vld, redir_pc, redir_src} !==
        {1'b1, 32'h1c0001C0, 2'd3})
      $display("FAIL bcond_bwd: got v=%b pc=%h s=%0d want v=1 pc=1c0001c0 s=3",
               redir_vld, redir_pc, redir_src);
    else npass++;
    adv();
  endtask

  task automatic test_hold_overwrite();
    redir_rdy = 0;
    dec_valid = 1; dec_jump = 1;
    dec_pc = 32'h1c000300; dec_offs = 32'h00000010;
    for (int c = 0; c < 3; c++) begin
      adv();
      smp();
      ntot++;
      if ({redir_vld, redir_pc, dec_stall} !==
          {1'b1, 32'h1c000310, 1'b1})
        $display("FAIL hold_c%0d: got v=%b pc=%h st=%b want v=1 pc=1c000310 st=1",
                 c, redir_vld, redir_pc, dec_stall);
      else npass++;
    end
    adv();
    exu_vld = 1; exu_pc = 32'h1c008000;
    adv();
    clr_req();
    smp();
    ntot++;
    if ({redir_pc, redir_src, dec_stall} !==
        {32'h1c008000, 2'd2, 1'b0})
      $display("FAIL hold_exu: got pc=%h s=%0d st=%b want pc=1c008000 s=2 st=0",
               redir_pc, redir_src, dec_stall);
    else npass++;
    redir_rdy = 1;
    adv();
    redir_rdy = 0;
  endtask

  task automatic test_exc_prio();
    exc_vld = 1; exc_pc = 32'h1c000400;
    exu_vld = 1; exu_pc = 32'h1c000500;
    dec_valid = 1; dec_jump = 1;
    dec_pc = 32'h1c000600; dec_offs = 32'h8;
    adv();
    clr_req();
    smp();
    ntot++;
    if ({redir_vld, redir_pc, redir_src} !==
        {1'b1, 32'h1c000400, 2'd1})
      $display("FAIL exc_prio: got v=%b pc=%h s=%0d want v=1 pc=1c000400 s=1",
               redir_vld, redir_pc, redir_src);
    else npass++;
    exu_vld = 1; exu_pc = 32'h1c000700;
    adv();
    clr_req();
    smp();
    ntot++;
    if ({redir_vld, redir_pc, redir_src} !==
        {1'b1, 32'h1c000400, 2'd1})
      $display("FAIL exc_keep: got v=%b pc=%h s=%0d want v=1 pc=1c000400 s=1",
               redir_vld, redir_pc, redir_src);
    else npass++;
    redir_rdy = 1;
    adv();
    redir_rdy = 0;
  endtask

  task automatic test_back_to_back();
    dec_valid = 1; dec_jump = 1;
    dec_pc = 32'h1c001000; dec_offs = 32'h20;
    adv();
    clr_req();
    redir_rdy = 1;
    exu_vld = 1; exu_pc = 32'h1c002000;
    adv();
    clr_req();
    smp();
    ntot++;
    if ({redir_vld, redir_pc, redir_src, fetch_kill} !==
        {1'b1, 32'h1c002000, 2'd2, 1'b1})
      $display("FAIL b2b_first: got v=%b pc=%h s=%0d k=%b want v=1 pc=1c002000 s=2 k=1",
               redir_vld, redir_pc, redir_src, fetch_kill);
    else npass++;
    adv();
    redir_rdy = 0;
    smp();
    ntot++;
    if ({redir_vld, fetch_kill} !== 2'b01)
      $display("FAIL b2b_second: got v=%b k=%b want v=0 k=1",
               redir_vld, fetch_kill);
    else npass++;
    adv();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      resetn    = ($urandom_range(0, 63) != 0);
      redir_rdy = $urandom_range(0, 2) != 0;
      dec_valid = $urandom_range(0, 1);
      dec_jump  = $urandom_range(0, 3) == 0;
      dec_bcond = $urandom_range(0, 1);
      dec_pc    = $urandom & 32'hFFFFFFFC;
      dec_offs  = $urandom & 32'hFFFFFFFC;
      exu_vld   = $urandom_range(0, 4) == 0;
      exu_pc    = $urandom;
      exc_vld   = $urandom_range(0, 9) == 0;
      exc_pc    = $urandom;
      smp();
      ntot++;
      if ({redir_vld, redir_src, fetch_kill,
           dec_stall} !==
          {m_pend, m_src, m_kill, m_stall()} ||
          (m_pend && redir_pc !== m_pc))
        $display("FAIL rand_c%0d: got v=%b pc=%h s=%0d k=%b st=%b want v=%b pc=%h s=%0d k=%b st=%b",
                 c, redir_vld, redir_pc, redir_src,
                 fetch_kill, dec_stall, m_pend, m_pc,
                 m_src, m_kill, m_stall());
      else npass++;
      adv();
    end
    resetn = 1;
  endtask

  initial begin
    test_reset();
    test_dec_jump();
    test_bcond();
    test_hold_overwrite();
    test_exc_prio();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
